// File: rtl/fft_stream_r2.sv
// fft_stream_r2 -- streaming radix-2 decimation-in-time FFT on real samples.
//
// Loads N = 2**LOG2N signed real samples serially in bit-reversed order, then
// runs LOG2N stages in place with one shared butterfly per cycle. Twiddles
// are Q2.14 constants with round-half-up. Finally it unloads N complex bins
// in natural order.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/ready    sample stream handshake; in_data is a signed DW-bit x[n]
//   out_valid/ready   bin stream handshake
//   out_re/out_im     signed OW-bit X[k], where OW = DW+LOG2N+1
//   out_index         bin index k
//   out_last          high with bin k = N-1
//   busy              high while computing or unloading
module fft_stream_r2 #(
    parameter int LOG2N = 3,
    parameter int DW    = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DW-1:0]     in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DW+LOG2N:0] out_re,
    output logic signed [DW+LOG2N:0] out_im,
    output logic [LOG2N-1:0]         out_index,
    output logic                     out_last,
    output logic                     busy
);
    localparam int N  = 1 << LOG2N;
    localparam int OW = DW + LOG2N + 1;
    localparam int PW = OW + 16;   // full product width
    localparam int AW = OW + 17;   // product-pair sum width
    localparam logic [1:0] LAST_STAGE = 2'(LOG2N - 1);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;
    state_t state, state_nx;

    // cnt is the sample count in LOAD and the bin index in UNLOAD.
    // It wraps to zero at the end of both phases.
    logic [LOG2N-1:0] cnt;
    logic [LOG2N-2:0] bf;
    logic [1:0]       stage;

    logic signed [OW-1:0] mem_re [N];
    logic signed [OW-1:0] mem_im [N];

    logic [LOG2N-1:0] ld_addr, bfx, half, lowmask, pos, a_addr, b_addr, tw_k;
    logic [3:0]        tw_idx;
    logic signed [15:0] w_cos, w_sin;
    logic signed [OW-1:0] a_re, a_im, b_re, b_im, t_re, t_im;
    logic signed [PW-1:0] p_rc, p_is, p_ic, p_rs;
    logic signed [AW-1:0] sum_re, sum_im;

    always_comb begin
        ld_addr = '0;
        for (int unsigned i = 0; i < LOG2N; i++)
            ld_addr[i] = cnt[LOG2N-1-i];
    end

    // A stage-s butterfly pair is found by inserting a 0 (for a) or a 1
    // (for b) at bit s of the butterfly counter. The twiddle index is the
    // position within the group, scaled up to the N-point table.
    always_comb begin
        bfx     = {1'b0, bf};
        half    = LOG2N'(1) << stage;
        lowmask = half - 1'b1;
        pos     = bfx & lowmask;
        a_addr  = ((bfx & ~lowmask) << 1) | pos;
        b_addr  = a_addr | half;
        tw_k    = pos << (LAST_STAGE - stage);
        tw_idx  = 4'(tw_k) << (4 - LOG2N);
    end

    // Twiddle table for 16 points: cos and sin of 2*pi*k/16 times 16384.
    // An 8-point transform uses the even entries.
    always_comb begin
        w_cos = 16'sd16384;
        w_sin = 16'sd0;
        case (tw_idx)
            4'd1: begin w_cos =  16'sd15137; w_sin = 16'sd6270;  end
            4'd2: begin w_cos =  16'sd11585; w_sin = 16'sd11585; end
            4'd3: begin w_cos =  16'sd6270;  w_sin = 16'sd15137; end
            4'd4: begin w_cos =  16'sd0;     w_sin = 16'sd16384; end
            4'd5: begin w_cos = -16'sd6270;  w_sin = 16'sd15137; end
            4'd6: begin w_cos = -16'sd11585; w_sin = 16'sd11585; end
            4'd7: begin w_cos = -16'sd15137; w_sin = 16'sd6270;  end
            default: ;
        endcase
    end

    // t = b * (cos - j sin), rounded half-up from Q2.14.
    always_comb begin
        a_re   = mem_re[a_addr];
        a_im   = mem_im[a_addr];
        b_re   = mem_re[b_addr];
        b_im   = mem_im[b_addr];
        p_rc   = PW'(b_re) * PW'(w_cos);
        p_is   = PW'(b_im) * PW'(w_sin);
        p_ic   = PW'(b_im) * PW'(w_cos);
        p_rs   = PW'(b_re) * PW'(w_sin);
        sum_re = AW'(p_rc) + AW'(p_is) + AW'(8192);
        sum_im = AW'(p_ic) - AW'(p_rs) + AW'(8192);
        t_re   = OW'(sum_re >>> 14);
        t_im   = OW'(sum_im >>> 14);
    end

    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid) begin
            mem_re[ld_addr] <= OW'(in_data);
            mem_im[ld_addr] <= '0;
        end else if (state == S_COMPUTE) begin
            mem_re[a_addr] <= a_re + t_re;
            mem_im[a_addr] <= a_im + t_im;
            mem_re[b_addr] <= a_re - t_re;
            mem_im[b_addr] <= a_im - t_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LOAD;
            cnt   <= '0;
            bf    <= '0;
            stage <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_LOAD:    if (in_valid) cnt <= cnt + 1'b1;
                S_COMPUTE: begin
                    bf <= bf + 1'b1;
                    if (&bf) stage <= (stage == LAST_STAGE) ? 2'd0 : stage + 2'd1;
                end
                S_UNLOAD:  if (out_ready) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && &cnt) state_nx = S_COMPUTE;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (&bf && stage == LAST_STAGE) state_nx = S_UNLOAD;
            end
            S_UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && &cnt) state_nx = S_LOAD;
            end
            default: state_nx = S_LOAD;
        endcase
    end

    always_comb begin
        out_re    = out_valid ? mem_re[cnt] : '0;
        out_im    = out_valid ? mem_im[cnt] : '0;
        out_index = out_valid ? cnt : '0;
        out_last  = out_valid && (&cnt);
    end
endmodule

// File: doc/fft_stream_r2.md
Name: fft_stream_r2

Overview:
- Sequential, parametrised radix-2 DIT FFT on real signed samples; successor to the combinational 8-point FFT datapath.
- Accepts N samples serially over a valid/ready stream and computes in place with one shared butterfly per cycle.
- Emits N complex bins serially in natural order.
- Replaces the fixed 10x twiddle scaling with Q2.14 twiddles and rounding.

Parameters:
- LOG2N, 3, log2 of transform size N (legal values 3 or 4, so N = 8 or 16).
- DW, 12, input sample width (signed).
- OW, DW+LOG2N+1, output width (signed); derived localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  DW  signed real sample x[n], n = 0..N-1 in arrival order.
- out_valid  out  1  out_re/out_im/out_index valid.
- out_ready  in  1  downstream accepts the bin.
- out_re  out  OW  signed real part of X[k].
- out_im  out  OW  signed imaginary part of X[k].
- out_index  out  LOG2N  bin index k.
- out_last  out  1  high with bin k = N-1.
- busy  out  1  high in COMPUTE or UNLOAD.

Behaviour:
- Reset (async assert, sync deassert): state = LOAD, sample count = 0, in_ready = 1, out_valid = 0, out_re = out_im = 0, out_index = 0, out_last = 0, busy = 0. Data RAM contents are don't-care.
- Storage: N complex registers, each OW bits re and OW bits im.
- LOAD:
  - in_ready = 1; a sample transfers on in_valid & in_ready.
  - Sample n is sign-extended to OW bits and written to the real part at address bitrev(n); the imaginary part is cleared.
  - On the N-th transfer, go to COMPUTE next cycle, with in_ready = 0 from that cycle.
- COMPUTE:
  - Runs LOG2N stages of N/2 butterflies, one butterfly per cycle, so LOG2N*N/2 cycles (12 for N=8, 32 for N=16).
  - Butterfly on pair (a, b), twiddle W = exp(-j2πk/N) for k = 0..N/2-1, stored as a 16-bit Q2.14 constant ROM (cos and sin times 16384, rounded to nearest).
  - t = b*W: each of the 4 products is computed at full width. Sum the re pair and the im pair, add 2^13, arithmetic shift right by 14, truncate to OW.
  - Write a' = a + t and b' = a - t to the same addresses at the clock edge ending the cycle.
  - No saturation is needed: OW covers N*2^(DW-1) plus rounding.
  - After the last butterfly, go to UNLOAD.
- UNLOAD:
  - out_valid = 1 starting the first UNLOAD cycle; bins are presented k = 0..N-1 from address k (natural order).
  - Outputs hold stable while out_valid & !out_ready.
  - Advance on out_valid & out_ready. out_last = 1 exactly when k = N-1.
  - After the last handshake: out_valid = 0 the next cycle, state = LOAD, in_ready = 1, busy = 0.
- Latency from the last input handshake to first out_valid is 1 + LOG2N*N/2 cycles.
- Stall behaviour: in_valid low during LOAD stalls without losing the count. out_ready low stalls indefinitely.
- No input is accepted during COMPUTE or UNLOAD (in_ready = 0); no overlap between frames.
- Reset mid-operation, in any state, aborts the frame immediately. The first sample after reset is x[0].
- in_data is ignored when in_ready = 0; out_ready is ignored when out_valid = 0.

Test Plan:
- Reference vector: N=8, DW=12, inputs 10,4,-3,5,-10,9,-13,-11 with in_valid held high -> X0 = -9+0i, X2 = 16-19i, X4 = -23+0i, X6 = 16+19i (exact). X1/X7 and X3/X5 are conjugate pairs within ±1 LSB of a double-precision model. First out_valid occurs 13 cycles after the last input handshake.
- Impulse and DC, N=8: x = 100,0,...,0 -> every bin 100+0i. x = 10 on all samples -> X0 = 80+0i, all other bins 0+0i exactly.
- Tone, N=16, DW=12: x[n] = round(2047*cos(2πn/16)) -> X1 and X15 = 16376±2 +0±2i, all other bins within ±2. Full-scale x = -2048 on all samples -> X0 = -32768, no wrap.
- Handshake stress: random in_valid gaps during LOAD and random out_ready stalls during UNLOAD -> identical bin values to the unstalled run. Outputs stay stable while stalled. out_last pulses only on k=7, and in_ready = 0 throughout COMPUTE/UNLOAD.
- Reset mid-operation: assert rst_n low during cycle 5 of COMPUTE, then during bin 3 of UNLOAD -> outputs return to reset values asynchronously. A following clean frame produces correct reference-vector results.
- Back-to-back frames: three frames with different inputs, out_ready tied high -> the next frame's first sample is accepted the cycle after the previous frame's out_last handshake. Each frame's bins match the model.
